// File: rtl/result_readout_pkg.sv
// Shared widths and FSM encoding for the result BRAM readout path.
package result_readout_pkg;

    localparam int unsigned RESULT_SIZE   = 32;
    localparam int unsigned ADDR_SIZE     = 10;
    localparam int unsigned OUT_W_DEFAULT = 8;

    typedef enum logic [1:0] {
        StIdle,
        StRead,
        StDrain,
        StDone
    } rr_state_e;

endpackage

// File: rtl/sync_fifo_small.sv
// Small synchronous FIFO with occupancy count; push while full is accepted only alongside a pop.
module sync_fifo_small #(
    parameter int unsigned Width = 8,
    parameter int unsigned Depth = 2
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         push_i,
    input  logic [Width-1:0]             wdata_i,
    input  logic                         pop_i,
    output logic [Width-1:0]             rdata_o,
    output logic                         empty_o,
    output logic [$clog2(Depth+1)-1:0]   count_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wptr_q, rptr_q;
    logic [CntW-1:0]  count_q;
    logic             full, do_push, do_pop;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count_q == CntW'(Depth));
    assign empty_o = (count_q == '0);
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full || do_pop);
    assign rdata_o = mem_q[rptr_q];
    assign count_o = count_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(Depth); i++) mem_q[i] <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                mem_q[wptr_q] <= wdata_i;
                wptr_q        <= ptr_inc(wptr_q);
            end
            if (do_pop) rptr_q <= ptr_inc(rptr_q);
            if (do_push && !do_pop)      count_q <= count_q + 1'b1;
            else if (do_pop && !do_push) count_q <= count_q - 1'b1;
        end
    end

endmodule

// File: rtl/result_readout.sv
// Sequential readback of the result BRAM with ReLU, rounding requant and saturation,
// delivered as a valid/ready stream; a credit check keeps the BRAM latency from overflowing the FIFO.
module result_readout
    import result_readout_pkg::*;
#(
    parameter int unsigned OUT_W      = OUT_W_DEFAULT,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   w_done_i,
    input  logic [ADDR_SIZE-1:0]   total_words_i,
    input  logic                   relu_en_i,
    input  logic [4:0]             shift_i,
    output logic                   rd_en_o,
    output logic [ADDR_SIZE-1:0]   rd_addr_o,
    input  logic [RESULT_SIZE-1:0] rd_data_i,
    output logic [OUT_W-1:0]       m_data_o,
    output logic                   m_valid_o,
    input  logic                   m_ready_i,
    output logic                   m_last_o,
    output logic                   busy_o,
    output logic                   done_o
);

    localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
    localparam logic signed [RESULT_SIZE:0] SatMax = (RESULT_SIZE+1)'((1 << (OUT_W - 1)) - 1);
    localparam logic signed [RESULT_SIZE:0] SatMin = -SatMax - 1;

    rr_state_e            state_q, state_d;
    logic [ADDR_SIZE:0]   cnt_q, cnt_d;
    logic [ADDR_SIZE-1:0] total_q, total_d;
    logic                 relu_q, relu_d;
    logic [4:0]           shift_q, shift_d;
    logic                 w_done_q, inflight_q, infl_last_q;
    logic                 start, pop, credit_ok, last_issue;

    logic                 fifo_empty;
    logic [CntW-1:0]      fifo_count;
    logic [OUT_W:0]       fifo_rdata;

    logic signed [RESULT_SIZE-1:0] x;
    logic signed [RESULT_SIZE:0]   xg, rnd, y;
    logic [OUT_W-1:0]              sat;

    assign start     = w_done_i && !w_done_q && (state_q == StIdle);
    assign pop       = m_valid_o && m_ready_i;
    // Entries already held plus the one in the BRAM pipe must leave room for this issue.
    assign credit_ok = (32'(fifo_count) + 32'(inflight_q)) < (FIFO_DEPTH + 32'(pop));
    assign last_issue = (cnt_q == {1'b0, total_q} - 1'b1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        total_d = total_q;
        relu_d  = relu_q;
        shift_d = shift_q;
        rd_en_o = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    total_d = total_words_i;
                    relu_d  = relu_en_i;
                    shift_d = shift_i;
                    cnt_d   = '0;
                    state_d = (total_words_i == '0) ? StDone : StRead;
                end
            end
            StRead: begin
                if (credit_ok && (cnt_q < {1'b0, total_q})) begin
                    rd_en_o = 1'b1;
                    cnt_d   = cnt_q + 1'b1;
                    if (last_issue) state_d = StDrain;
                end
            end
            StDrain: begin
                if (!inflight_q && (32'(fifo_count) == 32'(pop))) state_d = StDone;
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            total_q     <= '0;
            relu_q      <= 1'b0;
            shift_q     <= '0;
            w_done_q    <= 1'b0;
            inflight_q  <= 1'b0;
            infl_last_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            total_q     <= total_d;
            relu_q      <= relu_d;
            shift_q     <= shift_d;
            w_done_q    <= w_done_i;
            inflight_q  <= rd_en_o;
            infl_last_q <= rd_en_o && last_issue;
        end
    end

    // One guard bit keeps the rounding add from wrapping at the positive extreme.
    always_comb begin
        x = rd_data_i;
        if (relu_q && x[RESULT_SIZE-1]) x = '0;
        xg  = {x[RESULT_SIZE-1], x};
        rnd = '0;
        y   = xg;
        if (shift_q != '0) begin
            rnd = (RESULT_SIZE+1)'(1) << (shift_q - 5'd1);
            y   = (xg + rnd) >>> shift_q;
        end
        if (y > SatMax)      sat = SatMax[OUT_W-1:0];
        else if (y < SatMin) sat = SatMin[OUT_W-1:0];
        else                 sat = y[OUT_W-1:0];
    end

    sync_fifo_small #(
        .Width(OUT_W + 1),
        .Depth(FIFO_DEPTH)
    ) u_fifo (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .push_i (inflight_q),
        .wdata_i({infl_last_q, sat}),
        .pop_i  (pop),
        .rdata_o(fifo_rdata),
        .empty_o(fifo_empty),
        .count_o(fifo_count)
    );

    assign rd_addr_o = cnt_q[ADDR_SIZE-1:0];
    assign m_valid_o = !fifo_empty;
    assign m_data_o  = fifo_rdata[OUT_W-1:0];
    assign m_last_o  = fifo_rdata[OUT_W];
    assign busy_o    = (state_q == StRead) || (state_q == StDrain);
    assign done_o    = (state_q == StDone);

endmodule

// File: tb/tb_result_readout.sv
// Randomized scoreboard bench for result_readout with a BRAM model and an arithmetic requant model.
module tb_result_readout;
    import result_readout_pkg::*;

    localparam int unsigned OW = 8;
    localparam int unsigned FD = 2;

    typedef struct {
        longint data;
        bit     last;
    } beat_t;

    logic                   clk, rst_n, w_done, relu_en, m_ready;
    logic [ADDR_SIZE-1:0]   total_words, rd_addr;
    logic [4:0]             shift;
    logic                   rd_en, m_valid, m_last, busy, done;
    logic [RESULT_SIZE-1:0] rd_data;
    logic [OW-1:0]          m_data;

    int    mem [1024];
    beat_t exp_q[$];
    int    checks = 0, passes = 0;
    int    ready_pct = 100;
    int    run_issue = 0, run_beats = 0, exp_addr = 0, run_total = 0, credit_viol = 0;
    bit    stall = 0;
    logic [OW-1:0] hold_data;
    logic          hold_last;

    result_readout #(.OUT_W(OW), .FIFO_DEPTH(FD)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .w_done_i     (w_done),
        .total_words_i(total_words),
        .relu_en_i    (relu_en),
        .shift_i      (shift),
        .rd_en_o      (rd_en),
        .rd_addr_o    (rd_addr),
        .rd_data_i    (rd_data),
        .m_data_o     (m_data),
        .m_valid_o    (m_valid),
        .m_ready_i    (m_ready),
        .m_last_o     (m_last),
        .busy_o       (busy),
        .done_o       (done)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    always @(posedge clk) if (rd_en) rd_data <= 32'(mem[rd_addr]);

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Floor-division rounding on plain integers, then clamp to the signed output range.
    function automatic longint model(input longint x, input bit relu, input int sh);
        longint d, n, q;
        if (relu && x < 0) x = 0;
        q = x;
        if (sh > 0) begin
            d = longint'(1) << sh;
            n = x + d / 2;
            q = n / d;
            if (n < 0 && (n % d) != 0) q = q - 1;
        end
        if (q > 127) q = 127;
        if (q < -128) q = -128;
        return q;
    endfunction

    initial begin
        m_ready = 1;
        forever begin
            @(posedge clk);
            #1 m_ready = ($urandom_range(0, 99) < ready_pct);
        end
    end

    // Monitor: credit invariant, read-address sequencing, scoreboard pop, stall stability.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stall = 0;
            end else begin
                if (run_issue - run_beats > int'(FD)) credit_viol++;
                if (rd_en) begin
                    chk("rd_addr_seq", longint'(rd_addr), exp_addr);
                    chk("rd_addr_bound", longint'(rd_addr < run_total), 1);
                    exp_addr++;
                    run_issue++;
                end
                if (stall) begin
                    chk("stall_valid", longint'(m_valid), 1);
                    chk("stall_data", longint'(m_data), longint'(hold_data));
                    chk("stall_last", longint'(m_last), longint'(hold_last));
                end
                if (m_valid && m_ready) begin
                    stall = 0;
                    run_beats++;
                    if (exp_q.size() == 0) begin
                        chk("unexpected_beat", 1, 0);
                    end else begin
                        beat_t e;
                        e = exp_q.pop_front();
                        chk("beat_data", longint'($signed(m_data)), e.data);
                        chk("beat_last", longint'(m_last), longint'(e.last));
                    end
                end else if (m_valid) begin
                    stall = 1;
                    hold_data = m_data;
                    hold_last = m_last;
                end else begin
                    stall = 0;
                end
            end
        end
    end

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_rd_en"}, longint'(rd_en), 0);
        chk({tag, "_rd_addr"}, longint'(rd_addr), 0);
        chk({tag, "_m_data"}, longint'(m_data), 0);
        chk({tag, "_m_valid"}, longint'(m_valid), 0);
        chk({tag, "_m_last"}, longint'(m_last), 0);
        chk({tag, "_busy"}, longint'(busy), 0);
        chk({tag, "_done"}, longint'(done), 0);
    endtask

    // exp_done <= 0 skips the exact done-cycle check; abort_beat >= 0 resets the DUT mid-run.
    task automatic run(input int n, input bit relu, input int sh, input int rdy,
                       input int exp_done, input int abort_beat);
        int done_cyc;
        ready_pct   = rdy;
        total_words = ADDR_SIZE'(n);
        relu_en     = relu;
        shift       = 5'(sh);
        exp_q.delete();
        for (int i = 0; i < n; i++) begin
            beat_t e;
            e.data = model(longint'(mem[i]), relu, sh);
            e.last = (i == n - 1);
            exp_q.push_back(e);
        end
        run_issue = 0; run_beats = 0; exp_addr = 0; run_total = n; credit_viol = 0;
        @(posedge clk);
        #1 w_done = 1;
        @(posedge clk);
        done_cyc = -1;
        for (int c = 1; c <= 3000; c++) begin
            @(negedge clk);
            #1;
            if (c == 1) chk("busy_cycle1", longint'(busy), longint'(n > 0));
            if (abort_beat >= 0 && run_beats >= abort_beat) begin
                rst_n = 0;
                #1;
                chk_reset_vals("midrun_reset");
                exp_q.delete();
                w_done = 0;
                repeat (2) @(negedge clk);
                rst_n = 1;
                return;
            end
            if (done) begin
                done_cyc = c;
                break;
            end
        end
        chk("done_seen", longint'(done_cyc > 0), 1);
        if (exp_done > 0) chk("done_cycle", done_cyc, exp_done);
        chk("busy_at_done", longint'(busy), 0);
        chk("beat_count", run_beats, n);
        chk("issue_count", run_issue, n);
        chk("scoreboard_empty", exp_q.size(), 0);
        chk("credit_ok", credit_viol, 0);
        w_done = 0;
        @(negedge clk);
        #1 chk("done_one_cycle", longint'(done), 0);
    endtask

    initial begin
        rst_n = 0; w_done = 0; relu_en = 0; shift = '0; total_words = '0;
        for (int i = 0; i < 1024; i++) mem[i] = 0;
        repeat (2) @(negedge clk);
        chk_reset_vals("reset");
        rst_n = 1;

        mem[0] = 10; mem[1] = -5; mem[2] = 300; mem[3] = 7;
        run(4, 0, 0, 100, 7, -1);
        run(4, 1, 1, 100, 7, -1);

        mem[0] = -129;
        run(1, 0, 0, 100, 4, -1);
        mem[0] = 255;
        run(1, 0, 2, 100, 4, -1);

        for (int i = 0; i < 16; i++) mem[i] = $urandom_range(0, 4000) - 2000;
        run(16, 0, 3, 30, 0, -1);

        run(0, 0, 0, 100, 1, -1);

        for (int k = 0; k < 3; k++) begin
            int n;
            n = $urandom_range(1, 20);
            for (int i = 0; i < n; i++) mem[i] = int'($urandom());
            run(n, 1'($urandom_range(0, 1)), $urandom_range(0, 31), 60, 0, -1);
        end

        for (int i = 0; i < 8; i++) mem[i] = (i * 37) - 100;
        run(8, 0, 1, 100, 0, 3);
        run(8, 0, 1, 100, 11, -1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
